// File: rtl/instruction_writeback.sv
// Final pipeline stage: retires one instruction per handshake, waits a bounded
// time for load data, aligns/extends it and drives the register-file write port.
module instruction_writeback #(
  parameter int unsigned RSP_TIMEOUT = 16,
  parameter logic [4:0]  OP_LOAD     = 5'd1,
  parameter logic [4:0]  OP_STORE    = 5'd2,
  parameter logic [4:0]  OP_BRANCH   = 5'd3
) (
  input  logic        clk,
  input  logic        rstf,
  input  logic [31:0] t_instr,
  input  logic        t_instr_valid,
  output logic        t_instr_ready,
  input  logic [31:0] iPC,
  input  logic [4:0]  iDecodedOP,
  input  logic [31:0] maAluValue,
  input  logic [31:0] dbus_rsp_data,
  input  logic        dbus_rsp_valid,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        retire_valid,
  output logic [31:0] retire_pc,
  output logic        load_timeout,
  output logic [63:0] instret
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(RSP_TIMEOUT);

  function automatic logic [31:0] align_load(input logic [31:0] data,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  a);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = 8'(data >> {a, 3'b000});
    half_v = 16'(data >> {a[1], 4'b0000});
    case (f3)
      3'b000:  align_load = {{24{byte_v[7]}}, byte_v};
      3'b001:  align_load = {{16{half_v[15]}}, half_v};
      3'b100:  align_load = {24'h000000, byte_v};
      3'b101:  align_load = {16'h0000, half_v};
      default: align_load = data;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        ret_q, ret_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic        to_q, to_d;
  logic [63:0] instret_q, instret_d;

  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        is_load;
  logic        wr_allowed;
  logic        accept;
  logic        unused_instr_bits;

  assign rd                = t_instr[11:7];
  assign funct3            = t_instr[14:12];
  assign unused_instr_bits = ^{t_instr[31:15], t_instr[6:0]};
  assign is_load           = (iDecodedOP == OP_LOAD);
  assign wr_allowed        = (iDecodedOP != OP_STORE) && (iDecodedOP != OP_BRANCH) && (rd != '0);
  assign t_instr_ready     = (state_q == IDLE);
  assign accept            = t_instr_valid & t_instr_ready;

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ret_d     = 1'b0;
    ret_pc_d  = ret_pc_q;
    to_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load && !dbus_rsp_valid) begin
            rd_d    = rd;
            f3_d    = funct3;
            addr_d  = maAluValue[1:0];
            pc_d    = iPC;
            cnt_d   = '0;
            state_d = WAIT_RSP;
          end else begin
            ret_d     = 1'b1;
            ret_pc_d  = iPC;
            wr_en_d   = wr_allowed;
            wr_addr_d = rd;
            wr_data_d = is_load ? align_load(dbus_rsp_data, funct3, maAluValue[1:0])
                                : maAluValue;
          end
        end
      end
      WAIT_RSP: begin
        // Response is checked before the deadline so a reply at the limit still wins.
        if (dbus_rsp_valid) begin
          ret_d     = 1'b1;
          ret_pc_d  = pc_q;
          wr_en_d   = (rd_q != '0);
          wr_addr_d = rd_q;
          wr_data_d = align_load(dbus_rsp_data, f3_q, addr_q);
          state_d   = IDLE;
        end else if (cnt_q >= TIMEOUT_CNT) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    instret_d = ret_d ? instret_q + 64'd1 : instret_q;
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      f3_q      <= '0;
      addr_q    <= '0;
      pc_q      <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ret_q     <= 1'b0;
      ret_pc_q  <= '0;
      to_q      <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ret_q     <= ret_d;
      ret_pc_q  <= ret_pc_d;
      to_q      <= to_d;
      instret_q <= instret_d;
    end
  end

  assign rf_wr_en     = wr_en_q;
  assign rf_wr_addr   = wr_addr_q;
  assign rf_wr_data   = wr_data_q;
  assign retire_valid = ret_q;
  assign retire_pc    = ret_pc_q;
  assign load_timeout = to_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_instruction_writeback.sv
// Self-checking bench for instruction_writeback: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_instruction_writeback;

  localparam int unsigned T = 4;
  localparam logic [4:0] OP_ALU    = 5'd0;
  localparam logic [4:0] OP_LOAD   = 5'd1;
  localparam logic [4:0] OP_STORE  = 5'd2;
  localparam logic [4:0] OP_BRANCH = 5'd3;
  localparam logic [4:0] OP_OTHER  = 5'd9;

  logic        clk = 1'b0;
  logic        rstf;
  logic [31:0] t_instr;
  logic        t_instr_valid;
  logic        t_instr_ready;
  logic [31:0] iPC;
  logic [4:0]  iDecodedOP;
  logic [31:0] maAluValue;
  logic [31:0] dbus_rsp_data;
  logic        dbus_rsp_valid;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        load_timeout;
  logic [63:0] instret;

  instruction_writeback #(
    .RSP_TIMEOUT(T),
    .OP_LOAD    (OP_LOAD),
    .OP_STORE   (OP_STORE),
    .OP_BRANCH  (OP_BRANCH)
  ) dut (
    .clk           (clk),
    .rstf          (rstf),
    .t_instr       (t_instr),
    .t_instr_valid (t_instr_valid),
    .t_instr_ready (t_instr_ready),
    .iPC           (iPC),
    .iDecodedOP    (iDecodedOP),
    .maAluValue    (maAluValue),
    .dbus_rsp_data (dbus_rsp_data),
    .dbus_rsp_valid(dbus_rsp_valid),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data),
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .load_timeout  (load_timeout),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  int          tests_run;
  int          tests_failed;
  logic [63:0] exp_instret;

  // Observations recorded by run_txn at the cycle the transaction completes.
  logic        obs_ready_acc, obs_hung, obs_ret, obs_wr, obs_to, obs_ready_after;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data, obs_pc;
  logic [63:0] obs_instret;
  int          obs_wait;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [2:0] f3);
    logic [31:0] r;
    r        = $urandom;
    r[11:7]  = rd;
    r[14:12] = f3;
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [31:0] addr);
    logic [31:0] v;
    int unsigned a;
    a = addr % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (d >> (8 * a)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (d >> (16 * (a / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic logic ref_wr(input logic [4:0] op, input logic [4:0] rd);
    return (op != OP_STORE) && (op != OP_BRANCH) && (rd != 5'd0);
  endfunction

  // Drives one transaction; lat = cycles after accept that the read data arrives
  // (0 = same cycle, negative = never). Records outputs at the completion cycle.
  task automatic run_txn(input logic [4:0] op, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [31:0] rdata, input int lat);
    int cyc;
    t_instr        = mk_instr(rd, f3);
    iDecodedOP     = op;
    maAluValue     = alu;
    iPC            = pc;
    t_instr_valid  = 1'b1;
    dbus_rsp_valid = (lat == 0);
    dbus_rsp_data  = (lat == 0) ? rdata : $urandom;
    obs_ready_acc  = t_instr_ready;
    step();
    t_instr_valid = 1'b0;
    t_instr       = $urandom;
    iPC           = $urandom;
    maAluValue    = $urandom;
    iDecodedOP    = OP_LOAD;
    cyc      = 0;
    obs_wait = 0;
    obs_hung = 1'b1;
    while (cyc < 64) begin
      if (retire_valid || load_timeout) begin
        obs_hung = 1'b0;
        break;
      end
      if (!t_instr_ready) obs_wait++;
      cyc++;
      dbus_rsp_valid = (cyc == lat);
      dbus_rsp_data  = (cyc == lat) ? rdata : $urandom;
      step();
    end
    obs_ret         = retire_valid;
    obs_wr          = rf_wr_en;
    obs_to          = load_timeout;
    obs_addr        = rf_wr_addr;
    obs_data        = rf_wr_data;
    obs_pc          = retire_pc;
    obs_instret     = instret;
    obs_ready_after = t_instr_ready;
    dbus_rsp_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rstf = 1'b0; t_instr_valid = 1'b0; dbus_rsp_valid = 1'b0;
    t_instr = '0; iPC = '0; iDecodedOP = '0; maAluValue = '0; dbus_rsp_data = '0;
    #12;
    tests_run++;
    if ({rf_wr_en, rf_wr_addr, rf_wr_data, retire_valid, retire_pc, load_timeout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h ret=%b pc=%h to=%b, want all 0",
               rf_wr_en, rf_wr_addr, rf_wr_data, retire_valid, retire_pc, load_timeout);
    end
    tests_run++;
    if (instret !== 64'd0) begin
      tests_failed++; $display("FAIL reset_instret: got %0d want 0", instret);
    end
    tests_run++;
    if (t_instr_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 1", t_instr_ready);
    end
    #2 rstf = 1'b1;
    step();
    exp_instret = 64'd0;
  endtask

  task automatic test_alu();
    run_txn(OP_ALU, 5'd5, 3'd0, 32'h0000_1234, 32'h0000_0100, 32'h0, -1);
    exp_instret++;
    tests_run++;
    if (obs_hung !== 1'b0 || obs_wait != 0 || obs_ret !== 1'b1) begin
      tests_failed++;
      $display("FAIL alu_latency: hung=%b wait=%0d ret=%b, want 0/0/1", obs_hung, obs_wait, obs_ret);
    end
    tests_run++;
    if (obs_wr !== 1'b1 || obs_addr !== 5'd5 || obs_data !== 32'h1234 || obs_pc !== 32'h100) begin
      tests_failed++;
      $display("FAIL alu_write: en=%b addr=%0d data=%h pc=%h, want 1/5/1234/100",
               obs_wr, obs_addr, obs_data, obs_pc);
    end
    tests_run++;
    if (obs_instret !== exp_instret) begin
      tests_failed++; $display("FAIL alu_instret: got %0d want %0d", obs_instret, exp_instret);
    end
    step();
    tests_run++;
    if (retire_valid !== 1'b0 || rf_wr_en !== 1'b0 || rf_wr_data !== 32'h1234 || rf_wr_addr !== 5'd5) begin
      tests_failed++;
      $display("FAIL alu_hold: ret=%b en=%b data=%h addr=%0d, want 0/0/1234/5",
               retire_valid, rf_wr_en, rf_wr_data, rf_wr_addr);
    end
  endtask

  task automatic test_store_rd0();
    logic [63:0] base;
    base = exp_instret;
    run_txn(OP_STORE, 5'd7, 3'd2, 32'hAAAA_0000, 32'h0000_0200, 32'h0, -1);
    tests_run++;
    if (obs_ret !== 1'b1 || obs_wr !== 1'b0) begin
      tests_failed++; $display("FAIL store_no_write: ret=%b en=%b, want 1/0", obs_ret, obs_wr);
    end
    run_txn(OP_ALU, 5'd0, 3'd0, 32'hBBBB_0000, 32'h0000_0204, 32'h0, -1);
    tests_run++;
    if (obs_ret !== 1'b1 || obs_wr !== 1'b0) begin
      tests_failed++; $display("FAIL rd0_no_write: ret=%b en=%b, want 1/0", obs_ret, obs_wr);
    end
    exp_instret = base + 64'd2;
    tests_run++;
    if (obs_instret !== exp_instret) begin
      tests_failed++; $display("FAIL store_rd0_instret: got %0d want %0d", obs_instret, exp_instret);
    end
  endtask

  task automatic test_load_wait();
    run_txn(OP_LOAD, 5'd9, 3'd0, 32'h1000_0003, 32'h0000_0300, 32'h80FF_FF00, 3);
    exp_instret++;
    tests_run++;
    if (obs_wait != 3 || obs_ret !== 1'b1 || obs_wr !== 1'b1 || obs_data !== 32'hFFFF_FF80 ||
        obs_pc !== 32'h300 || obs_addr !== 5'd9) begin
      tests_failed++;
      $display("FAIL lb_wait: wait=%0d ret=%b en=%b data=%h pc=%h addr=%0d, want 3/1/1/ffffff80/300/9",
               obs_wait, obs_ret, obs_wr, obs_data, obs_pc, obs_addr);
    end
    run_txn(OP_LOAD, 5'd10, 3'd4, 32'h1000_0003, 32'h0000_0304, 32'h80FF_FF00, 3);
    exp_instret++;
    tests_run++;
    if (obs_wait != 3 || obs_data !== 32'h0000_0080 || obs_instret !== exp_instret) begin
      tests_failed++;
      $display("FAIL lbu_wait: wait=%0d data=%h instret=%0d, want 3/00000080/%0d",
               obs_wait, obs_data, obs_instret, exp_instret);
    end
  endtask

  task automatic test_load_same_cycle();
    run_txn(OP_LOAD, 5'd11, 3'd1, 32'h2000_0002, 32'h0000_0400, 32'h8001_7FFF, 0);
    exp_instret++;
    tests_run++;
    if (obs_wait != 0 || obs_ret !== 1'b1 || obs_data !== 32'hFFFF_8001 || obs_pc !== 32'h400) begin
      tests_failed++;
      $display("FAIL lh_same_cycle: wait=%0d ret=%b data=%h pc=%h, want 0/1/ffff8001/400",
               obs_wait, obs_ret, obs_data, obs_pc);
    end
    run_txn(OP_LOAD, 5'd12, 3'd5, 32'h2000_0002, 32'h0000_0404, 32'h8001_7FFF, 0);
    exp_instret++;
    tests_run++;
    if (obs_wait != 0 || obs_data !== 32'h0000_8001) begin
      tests_failed++;
      $display("FAIL lhu_same_cycle: wait=%0d data=%h, want 0/00008001", obs_wait, obs_data);
    end
  endtask

  task automatic test_timeout();
    run_txn(OP_LOAD, 5'd13, 3'd2, 32'h3000_0000, 32'h0000_0500, 32'h0, -1);
    tests_run++;
    if (obs_hung !== 1'b0 || obs_to !== 1'b1 || obs_ret !== 1'b0 || obs_wr !== 1'b0 ||
        obs_wait != int'(T) + 1) begin
      tests_failed++;
      $display("FAIL timeout_pulse: hung=%b to=%b ret=%b en=%b wait=%0d, want 0/1/0/0/%0d",
               obs_hung, obs_to, obs_ret, obs_wr, obs_wait, T + 1);
    end
    tests_run++;
    if (obs_instret !== exp_instret || obs_ready_after !== 1'b1 || obs_data !== 32'h0000_8001) begin
      tests_failed++;
      $display("FAIL timeout_state: instret=%0d ready=%b data=%h, want %0d/1/00008001",
               obs_instret, obs_ready_after, obs_data, exp_instret);
    end
    dbus_rsp_valid = 1'b1;
    dbus_rsp_data  = 32'hDEAD_BEEF;
    step();
    dbus_rsp_valid = 1'b0;
    tests_run++;
    if (load_timeout !== 1'b0 || retire_valid !== 1'b0 || rf_wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_rsp_ignored: to=%b ret=%b en=%b, want 0/0/0", load_timeout, retire_valid, rf_wr_en);
    end
    step();
    run_txn(OP_LOAD, 5'd14, 3'd2, 32'h3000_0004, 32'h0000_0508, 32'h1357_9BDF, int'(T) + 1);
    exp_instret++;
    tests_run++;
    if (obs_to !== 1'b0 || obs_ret !== 1'b1 || obs_data !== 32'h1357_9BDF || obs_wait != int'(T) + 1) begin
      tests_failed++;
      $display("FAIL rsp_at_limit: to=%b ret=%b data=%h wait=%0d, want 0/1/13579bdf/%0d",
               obs_to, obs_ret, obs_data, obs_wait, T + 1);
    end
    step();
    tests_run++;
    if (load_timeout !== 1'b0 || retire_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsp_at_limit_after: to=%b ret=%b, want 0/0", load_timeout, retire_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds[8];
    logic [31:0] vals[8];
    logic [4:0]  ops[8];
    for (int i = 0; i < 8; i++) begin
      rds[i]  = 5'($urandom_range(0, 31));
      vals[i] = $urandom;
      ops[i]  = (i % 3 == 1) ? OP_STORE : OP_ALU;
    end
    for (int i = 0; i < 8; i++) begin
      t_instr       = mk_instr(rds[i], 3'($urandom));
      iDecodedOP    = ops[i];
      maAluValue    = vals[i];
      iPC           = 32'h0000_0600 + 32'(i * 4);
      t_instr_valid = 1'b1;
      step();
      exp_instret++;
      tests_run++;
      if (retire_valid !== 1'b1 || rf_wr_en !== ref_wr(ops[i], rds[i]) || rf_wr_addr !== rds[i] ||
          rf_wr_data !== vals[i] || retire_pc !== 32'h0000_0600 + 32'(i * 4) ||
          instret !== exp_instret || t_instr_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: ret=%b en=%b addr=%0d data=%h pc=%h instret=%0d rdy=%b, want 1/%b/%0d/%h/%h/%0d/1",
                 i, retire_valid, rf_wr_en, rf_wr_addr, rf_wr_data, retire_pc, instret, t_instr_ready,
                 ref_wr(ops[i], rds[i]), rds[i], vals[i], 32'h0000_0600 + 32'(i * 4), exp_instret);
      end
    end
    t_instr_valid = 1'b0;
    step();
    tests_run++;
    if (retire_valid !== 1'b0 || instret !== exp_instret) begin
      tests_failed++;
      $display("FAIL b2b_end: ret=%b instret=%0d, want 0/%0d", retire_valid, instret, exp_instret);
    end
  endtask

  task automatic test_random();
    logic [4:0]  op, rd;
    logic [2:0]  f3;
    logic [31:0] alu, pc, rdata, e_data, last_data;
    logic [4:0]  e_addr, last_addr;
    logic [31:0] last_pc;
    logic        e_ret, e_wr, e_to;
    int          lat, e_wait;
    run_txn(OP_ALU, 5'd1, 3'd0, 32'h0BAD_F00D, 32'h0000_0700, 32'h0, -1);
    exp_instret++;
    last_data = 32'h0BAD_F00D; last_addr = 5'd1; last_pc = 32'h0000_0700;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: op = OP_ALU;
        1: op = OP_STORE;
        2: op = OP_BRANCH;
        3: op = OP_OTHER;
        default: op = OP_LOAD;
      endcase
      if (n % 3 == 0) op = OP_LOAD;
      rd    = 5'($urandom_range(0, 31));
      f3    = 3'($urandom_range(0, 7));
      alu   = $urandom;
      pc    = $urandom;
      rdata = $urandom;
      lat   = $urandom_range(0, 7);
      if (op == OP_LOAD && lat > int'(T) + 1) begin
        e_ret = 1'b0; e_wr = 1'b0; e_to = 1'b1; e_wait = int'(T) + 1;
        e_data = last_data; e_addr = last_addr;
      end else begin
        e_ret = 1'b1; e_to = 1'b0; e_wr = ref_wr(op, rd); e_addr = rd;
        e_wait = (op == OP_LOAD) ? lat : 0;
        e_data = (op == OP_LOAD) ? ref_load(rdata, f3, alu) : alu;
        last_data = e_data; last_addr = e_addr; last_pc = pc;
        exp_instret++;
      end
      run_txn(op, rd, f3, alu, pc, rdata, (op == OP_LOAD) ? lat : -1);
      tests_run++;
      if (obs_hung !== 1'b0 || obs_ready_acc !== 1'b1 || obs_ret !== e_ret || obs_wr !== e_wr ||
          obs_to !== e_to || obs_wait != e_wait || obs_addr !== e_addr || obs_data !== e_data ||
          obs_pc !== last_pc || obs_instret !== exp_instret) begin
        tests_failed++;
        $display("FAIL rand[%0d] op=%0d f3=%0d lat=%0d: ret=%b en=%b to=%b wait=%0d addr=%0d data=%h pc=%h ic=%0d, want %b/%b/%b/%0d/%0d/%h/%h/%0d",
                 n, op, f3, lat, obs_ret, obs_wr, obs_to, obs_wait, obs_addr, obs_data, obs_pc,
                 obs_instret, e_ret, e_wr, e_to, e_wait, e_addr, e_data, last_pc, exp_instret);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    t_instr        = mk_instr(5'd15, 3'd0);
    iDecodedOP     = OP_LOAD;
    maAluValue     = 32'h4000_0001;
    iPC            = 32'h0000_0800;
    t_instr_valid  = 1'b1;
    dbus_rsp_valid = 1'b0;
    step();
    t_instr_valid = 1'b0;
    step();
    tests_run++;
    if (t_instr_ready !== 1'b0) begin
      tests_failed++; $display("FAIL mid_load_busy: ready=%b want 0", t_instr_ready);
    end
    rstf = 1'b0;
    #1;
    tests_run++;
    if ({rf_wr_en, rf_wr_addr, rf_wr_data, retire_valid, retire_pc, load_timeout} !== '0 ||
        instret !== 64'd0 || t_instr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_load_reset: en=%b addr=%0d data=%h ret=%b pc=%h to=%b ic=%0d rdy=%b, want zeros, rdy=1",
               rf_wr_en, rf_wr_addr, rf_wr_data, retire_valid, retire_pc, load_timeout, instret, t_instr_ready);
    end
    dbus_rsp_valid = 1'b1;
    #2 rstf = 1'b1;
    step();
    dbus_rsp_valid = 1'b0;
    tests_run++;
    if (retire_valid !== 1'b0 || rf_wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_load_discard: ret=%b en=%b, want 0/0", retire_valid, rf_wr_en);
    end
    exp_instret = 64'd0;
    run_txn(OP_ALU, 5'd3, 3'd0, 32'h0000_00AA, 32'h0000_0900, 32'h0, -1);
    exp_instret++;
    tests_run++;
    if (obs_ret !== 1'b1 || obs_instret !== exp_instret || obs_data !== 32'hAA) begin
      tests_failed++;
      $display("FAIL post_reset_addi: ret=%b instret=%0d data=%h, want 1/1/000000aa",
               obs_ret, obs_instret, obs_data);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_instret  = '0;
    test_reset();
    test_alu();
    test_store_rd0();
    test_load_wait();
    test_load_same_cycle();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
